load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-side responder for the execute stage's load/store requests. Takes the load address, store address and store data produced by the ALU for RV32I load (opcode 0000011) and store (opcode 0100011) instructions. Runs a word-addressed request/acknowledge bus transaction with byte strobes, then returns sign- or zero-extended load data for register-file writeback. Holds the core stalled while a transaction is outstanding and bounds every transaction with a timeout.

## Interface
- TIMEOUT_CYCLES, default 255: number of cycles in BUS without `bus_ack` before the transaction is abandoned; legal range 1..255.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  execute stage presents a memory instruction this cycle.
- opcode  in  7  instruction opcode; only 0000011 and 0100011 start a transaction.
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are loads only).
- read_address  in  32  load effective address (rs1+imm).
- write_address  in  32  store effective address (rs1+imm).
- store_data  in  32  store data, with the value in the low bits.
- stall  out  1  core must hold the pipeline.
- load_valid  out  1  one-cycle pulse; `load_data` is valid for writeback.
- load_data  out  32  extended load result.
- store_done  out  1  one-cycle pulse; the store completed.
- fault  out  1  one-cycle pulse; misaligned access or illegal funct3, with no bus activity.
- bus_error  out  1  one-cycle pulse; timeout expired.
- bus_addr  out  32  word address {addr[31:2],2'b00}.
- bus_read / bus_write  out  1 each  request strobes, mutually exclusive.
- bus_wdata  out  32  store data shifted to its byte lane.
- bus_wstrb  out  4  byte enables; 0000 on reads.
- bus_rdata  in  32  read data, sampled when `bus_ack`=1.
- bus_ack  in  1  transaction complete.

## Operation
- States: IDLE, BUS, DONE.
- IDLE, accept condition: `req_valid`=1, opcode is load or store, funct3 is legal for that opcode, and the access is aligned:
  - B/BU: any address.
  - H/HU: addr[0]=0.
  - W: addr[1:0]=00.
- IDLE, on accept:
  - Register the address (load uses `read_address`, store uses `write_address`), offset = addr[1:0], size, sign and direction.
  - Drive `bus_wstrb` = 0001/0011/1111 << offset.
  - Drive `bus_wdata` = store_data << (8*offset).
  - Go to BUS.
- IDLE, load/store opcode that fails the legality or alignment check: `fault`=1 for the next cycle only, then stay IDLE.
- IDLE, non-memory opcode: ignored; no outputs change.
- BUS:
  - Hold `bus_read` or `bus_write`, `bus_addr`, `bus_wdata` and `bus_wstrb` stable; increment the timeout counter (8-bit).
  - On `bus_ack`: for a load, `load_data` <= lane extract of `bus_rdata` >> (8*offset). B/H are sign-extended from bit 7/15; BU/HU are zero-extended; W passes through. Go to DONE.
  - If the counter reaches TIMEOUT_CYCLES with no ack: drop the strobes, set `load_data` <= 0, flag an error, go to DONE.
  - Ack in the same cycle the counter expires: the ack wins and no error is flagged.
- DONE, one cycle only:
  - Pulse `load_valid` (loads) or `store_done` (stores).
  - Pulse `bus_error` if the transaction timed out; `load_valid` and `store_done` stay 0 in that case.
  - Return to IDLE. `req_valid` is ignored in DONE.
- `stall` = (IDLE and accept condition true, combinational) or state==BUS. `stall` is 0 in DONE, so the core advances on the cycle `load_valid` is seen.
- `load_data` holds its last value until the next load completes or a timeout occurs.

## Timing
- Reset (asynchronous, rst=0):
  - State becomes IDLE and the counter clears.
  - All outputs are 0: `stall`, `load_valid`, `load_data`, `store_done`, `fault`, `bus_error`, `bus_addr`, `bus_read`, `bus_write`, `bus_wdata`, `bus_wstrb`.
  - Reset mid-transaction abandons the bus request immediately; no completion pulse follows.
- Accept at cycle N. Bus strobes are first visible at N+1.
- Ack sampled at cycle N+k (k≥1) gives DONE at N+k+1. Minimum latency from request to `load_valid` is 2 cycles.
- Timeout: strobes are asserted for exactly TIMEOUT_CYCLES cycles, then `bus_error` pulses in the following cycle.
- `fault` pulses in the cycle after the offending request. `stall` is never asserted for a faulting request.
- A `bus_ack` seen in IDLE or DONE is ignored.

## Test plan
- LW at 0x0000_1004, ack after 3 cycles with rdata 0xDEAD_BEEF:
  - `bus_addr`=0x0000_1004, `bus_read` asserted for 3 cycles.
  - Next cycle: `load_valid`=1, `load_data`=0xDEAD_BEEF.
  - `stall` high from the accept cycle through the ack cycle.
- LB vs LBU at 0x0000_2003, rdata 0x80_12_34_56:
  - LB gives 0xFFFF_FF80.
  - LBU gives 0x0000_0080.
  - LH at 0x0000_2002 gives 0xFFFF_8012.
- SB at 0x0000_3001, store_data 0x0000_00AB:
  - `bus_wstrb`=0010, `bus_wdata`=0x0000_AB00, `bus_write`=1.
  - After ack: `store_done` pulse, `bus_read` never asserted.
- Misalignment:
  - SW at 0x0000_4002: `fault` pulse next cycle, no bus strobe, `stall`=0.
  - LH at 0x0000_4001: same response.
  - Store with funct3=100: same response.
- Timeout with TIMEOUT_CYCLES=4 and no ack:
  - `bus_read` high for exactly 4 cycles, then a `bus_error` pulse, `load_data`=0, no `load_valid`.
  - Repeat with ack arriving in the 4th cycle: normal `load_valid`, no `bus_error`.
- rst asserted in the 2nd BUS cycle of an LW:
  - All outputs 0 immediately, state IDLE, no `load_valid` afterwards.
  - A new LW after release completes normally.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Word-addressed request/acknowledge memory bus with byte strobes.
// The load/store unit drives the request side (master); memory answers (slave).
interface load_store_unit_if;
    logic [31:0] bus_addr;
    logic        bus_read;
    logic        bus_write;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_addr, bus_read, bus_write, bus_wdata, bus_wstrb,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_addr, bus_read, bus_write, bus_wdata, bus_wstrb,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: accepts RV32I load/store requests from execute, runs one
// bus transaction at a time with byte strobes, returns extended load data,
// stalls the core while busy and abandons a transaction after a timeout.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [6:0]        opcode,
    input  logic [2:0]        funct3,
    input  logic [31:0]       read_address,
    input  logic [31:0]       write_address,
    input  logic [31:0]       store_data,
    output logic              stall,
    output logic              load_valid,
    output logic [31:0]       load_data,
    output logic              store_done,
    output logic              fault,
    output logic              bus_error,
    load_store_unit_if.master bus
);

    localparam logic [6:0] OP_LOAD       = 7'b0000011;
    localparam logic [6:0] OP_STORE      = 7'b0100011;
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  cnt;
    logic        timeout_hit;

    logic        is_load;
    logic        is_store;
    logic [31:0] req_addr;
    logic        f3_legal;
    logic        aligned;
    logic        accept;
    logic        reject;

    // Accepted transaction context, held for the whole BUS phase.
    logic [1:0]  acc_offset;
    logic [2:0]  acc_funct3;
    logic        acc_store;

    logic [31:0] addr_word;
    logic        rd_strobe;
    logic        wr_strobe;
    logic [31:0] wdata_lane;
    logic [3:0]  wstrb_lane;

    assign bus.bus_addr  = addr_word;
    assign bus.bus_read  = rd_strobe;
    assign bus.bus_write = wr_strobe;
    assign bus.bus_wdata = wdata_lane;
    assign bus.bus_wstrb = wstrb_lane;

    // Byte enables for an access of the given size at the given byte offset.
    function automatic logic [3:0] lane_strobe(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   lane_strobe = 4'b0001 << off;
            2'b01:   lane_strobe = 4'b0011 << off;
            default: lane_strobe = 4'b1111;
        endcase
    endfunction

    // Pull the addressed lane down to bit 0 and sign- or zero-extend it.
    function automatic logic [31:0] extend_load(input logic [31:0] rdata,
                                                input logic [1:0]  off,
                                                input logic [2:0]  f3);
        logic [31:0]        lane;
        logic signed [7:0]  byte_s;
        logic signed [15:0] half_s;
        logic signed [31:0] word_s;
        lane   = rdata >> {off, 3'b000};
        byte_s = $signed(lane[7:0]);
        half_s = $signed(lane[15:0]);
        case (f3)
            3'b000: begin
                word_s      = byte_s;
                extend_load = word_s;
            end
            3'b001: begin
                word_s      = half_s;
                extend_load = word_s;
            end
            3'b100:  extend_load = {24'd0, lane[7:0]};
            3'b101:  extend_load = {16'd0, lane[15:0]};
            default: extend_load = lane;
        endcase
    endfunction

    // Request decode: opcode class, funct3 legality and alignment.
    always_comb begin
        is_load  = (opcode == OP_LOAD);
        is_store = (opcode == OP_STORE);
        req_addr = is_store ? write_address : read_address;

        f3_legal = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
            3'b100, 3'b101:         f3_legal = is_load;
            default:                f3_legal = 1'b0;
        endcase

        aligned = 1'b0;
        case (funct3[1:0])
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~req_addr[0];
            2'b10:   aligned = (req_addr[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase

        // rst gates accept so stall stays low while reset is held.
        accept = rst && (state == IDLE) && req_valid && (is_load || is_store) && f3_legal && aligned;
        reject = rst && (state == IDLE) && req_valid && (is_load || is_store) && !(f3_legal && aligned);
    end

    // Ack takes priority over an expiring counter in the same cycle.
    assign timeout_hit = (state == BUS) && !bus.bus_ack && ((cnt + 8'd1) == TIMEOUT_LIMIT);

    // Next-state and stall.
    always_comb begin
        state_next = state;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                stall = accept;
                if (accept) state_next = BUS;
            end
            BUS: begin
                stall = 1'b1;
                if (bus.bus_ack || timeout_hit) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Timeout counter: cleared in IDLE, counts unacknowledged BUS cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                           cnt <= 8'd0;
        else if (state == IDLE)                             cnt <= 8'd0;
        else if (state == BUS && !bus.bus_ack && !timeout_hit) cnt <= cnt + 8'd1;
    end

    // Bus request registers, completion pulses and load result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_offset <= 2'd0;
            acc_funct3 <= 3'd0;
            acc_store  <= 1'b0;
            addr_word  <= 32'd0;
            rd_strobe  <= 1'b0;
            wr_strobe  <= 1'b0;
            wdata_lane <= 32'd0;
            wstrb_lane <= 4'd0;
            load_data  <= 32'd0;
            load_valid <= 1'b0;
            store_done <= 1'b0;
            fault      <= 1'b0;
            bus_error  <= 1'b0;
        end else begin
            load_valid <= 1'b0;
            store_done <= 1'b0;
            fault      <= 1'b0;
            bus_error  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc_offset <= req_addr[1:0];
                        acc_funct3 <= funct3;
                        acc_store  <= is_store;
                        addr_word  <= {req_addr[31:2], 2'b00};
                        rd_strobe  <= is_load;
                        wr_strobe  <= is_store;
                        wstrb_lane <= is_store ? lane_strobe(funct3, req_addr[1:0]) : 4'd0;
                        wdata_lane <= is_store ? (store_data << {req_addr[1:0], 3'b000}) : 32'd0;
                    end else if (reject) begin
                        fault <= 1'b1;
                    end
                end
                BUS: begin
                    if (bus.bus_ack) begin
                        rd_strobe  <= 1'b0;
                        wr_strobe  <= 1'b0;
                        wstrb_lane <= 4'd0;
                        load_valid <= !acc_store;
                        store_done <= acc_store;
                        if (!acc_store) load_data <= extend_load(bus.bus_rdata, acc_offset, acc_funct3);
                    end else if (timeout_hit) begin
                        rd_strobe  <= 1'b0;
                        wr_strobe  <= 1'b0;
                        wstrb_lane <= 4'd0;
                        load_data  <= 32'd0;
                        bus_error  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a short timeout so that the
// abandon path is reachable; memory side is driven by the stimulus script.
module tb_load_store_unit;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ALU   = 7'b0110011;
    localparam logic [31:0] OTHER_ADDR = 32'h0000_8000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] read_address;
    logic [31:0] write_address;
    logic [31:0] store_data;
    logic        stall;
    logic        load_valid;
    logic [31:0] load_data;
    logic        store_done;
    logic        fault;
    logic        bus_error;

    load_store_unit_if bif ();

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .opcode       (opcode),
        .funct3       (funct3),
        .read_address (read_address),
        .write_address(write_address),
        .store_data   (store_data),
        .stall        (stall),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .store_done   (store_done),
        .fault        (fault),
        .bus_error    (bus_error),
        .bus          (bif.master)
    );

    always #5 clk = ~clk;

    int          n_total = 0;
    int          n_bad   = 0;
    int          rd_cnt;
    int          wr_cnt;
    int          stall_lo;
    logic [31:0] first_addr;
    logic [31:0] first_wdata;
    logic [3:0]  first_strb;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one legal request from an IDLE cycle, ack in BUS cycle ack_cyc
    // (0 = never), and return positioned in the DONE cycle.
    task automatic run_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] sd, input int ack_cyc, input logic [31:0] rd);
        int cyc;
        req_valid     = 1'b1;
        opcode        = op;
        funct3        = f3;
        read_address  = (op == OP_LOAD)  ? addr : OTHER_ADDR;
        write_address = (op == OP_STORE) ? addr : OTHER_ADDR;
        store_data    = sd;
        #1;
        chk("stall_accept", 32'(stall), 1);
        tick();
        req_valid   = 1'b0;
        first_addr  = bif.bus_addr;
        first_wdata = bif.bus_wdata;
        first_strb  = bif.bus_wstrb;
        rd_cnt   = 0;
        wr_cnt   = 0;
        stall_lo = 0;
        cyc      = 0;
        while ((bif.bus_read || bif.bus_write) && cyc < 400) begin
            cyc++;
            if (bif.bus_read)  rd_cnt++;
            if (bif.bus_write) wr_cnt++;
            if (!stall)        stall_lo++;
            if (cyc == ack_cyc) begin
                bif.bus_ack   = 1'b1;
                bif.bus_rdata = rd;
            end
            tick();
            bif.bus_ack = 1'b0;
        end
    endtask

    // Present a load/store that must be refused without touching the bus.
    task automatic fault_op(input string tag, input logic [6:0] op, input logic [2:0] f3,
                            input logic [31:0] addr);
        req_valid     = 1'b1;
        opcode        = op;
        funct3        = f3;
        read_address  = (op == OP_LOAD)  ? addr : OTHER_ADDR;
        write_address = (op == OP_STORE) ? addr : OTHER_ADDR;
        store_data    = 32'hFFFF_FFFF;
        #1;
        chk({tag, "_stall"}, 32'(stall), 0);
        tick();
        req_valid = 1'b0;
        chk({tag, "_fault"}, 32'(fault), 1);
        chk({tag, "_strobes"}, 32'({bif.bus_read, bif.bus_write}), 0);
        tick();
        chk({tag, "_fault_pulse"}, 32'(fault), 0);
        chk({tag, "_strobes2"}, 32'({bif.bus_read, bif.bus_write}), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by time limit, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b0;
        req_valid     = 1'b0;
        opcode        = 7'd0;
        funct3        = 3'd0;
        read_address  = 32'd0;
        write_address = 32'd0;
        store_data    = 32'd0;
        bif.bus_ack   = 1'b0;
        bif.bus_rdata = 32'd0;
        tick();
        tick();

        // Reset state
        chk("rst_pulses", 32'({load_valid, store_done, fault, bus_error}), 0);
        chk("rst_load_data", load_data, 0);
        chk("rst_bus_addr", bif.bus_addr, 0);
        chk("rst_strobes", 32'({bif.bus_read, bif.bus_write}), 0);
        chk("rst_wdata", bif.bus_wdata, 0);
        chk("rst_wstrb", 32'(bif.bus_wstrb), 0);
        req_valid    = 1'b1;
        opcode       = OP_LOAD;
        funct3       = 3'b010;
        read_address = 32'h0000_1004;
        #1;
        chk("rst_stall", 32'(stall), 0);
        req_valid = 1'b0;
        rst       = 1'b1;
        tick();

        // LW, ack in third BUS cycle
        run_op(OP_LOAD, 3'b010, 32'h0000_1004, 32'd0, 3, 32'hDEAD_BEEF);
        chk("lw_addr", first_addr, 32'h0000_1004);
        chk("lw_wstrb", 32'(first_strb), 0);
        chk("lw_read_cycles", rd_cnt, 3);
        chk("lw_write_cycles", wr_cnt, 0);
        chk("lw_stall_bus", stall_lo, 0);
        chk("lw_valid", 32'(load_valid), 1);
        chk("lw_data", load_data, 32'hDEAD_BEEF);
        chk("lw_stall_done", 32'(stall), 0);
        chk("lw_err", 32'(bus_error), 0);
        tick();
        chk("lw_valid_pulse", 32'(load_valid), 0);

        // Byte/half extraction and extension
        run_op(OP_LOAD, 3'b000, 32'h0000_2003, 32'd0, 1, 32'h8012_3456);
        chk("lb_addr", first_addr, 32'h0000_2000);
        chk("lb_data", load_data, 32'hFFFF_FF80);
        tick();
        run_op(OP_LOAD, 3'b100, 32'h0000_2003, 32'd0, 1, 32'h8012_3456);
        chk("lbu_data", load_data, 32'h0000_0080);
        tick();
        run_op(OP_LOAD, 3'b001, 32'h0000_2002, 32'd0, 2, 32'h8012_3456);
        chk("lh_data", load_data, 32'hFFFF_8012);
        tick();
        run_op(OP_LOAD, 3'b101, 32'h0000_2002, 32'd0, 1, 32'h8012_3456);
        chk("lhu_data", load_data, 32'h0000_8012);
        tick();
        run_op(OP_LOAD, 3'b000, 32'h0000_2000, 32'd0, 1, 32'h8012_3456);
        chk("lb_pos_data", load_data, 32'h0000_0056);
        tick();

        // Stores: lane placement and strobes
        run_op(OP_STORE, 3'b000, 32'h0000_3001, 32'h0000_00AB, 1, 32'd0);
        chk("sb_addr", first_addr, 32'h0000_3000);
        chk("sb_wstrb", 32'(first_strb), 32'h2);
        chk("sb_wdata", first_wdata, 32'h0000_AB00);
        chk("sb_write_cycles", wr_cnt, 1);
        chk("sb_read_cycles", rd_cnt, 0);
        chk("sb_done", 32'(store_done), 1);
        chk("sb_no_lvalid", 32'(load_valid), 0);
        chk("sb_load_data_held", load_data, 32'h0000_0056);
        tick();
        chk("sb_done_pulse", 32'(store_done), 0);
        run_op(OP_STORE, 3'b001, 32'h0000_3002, 32'h0000_1234, 1, 32'd0);
        chk("sh_wstrb", 32'(first_strb), 32'hC);
        chk("sh_wdata", first_wdata, 32'h1234_0000);
        tick();
        run_op(OP_STORE, 3'b010, 32'h0000_3000, 32'hCAFE_F00D, 2, 32'd0);
        chk("sw_wstrb", 32'(first_strb), 32'hF);
        chk("sw_wdata", first_wdata, 32'hCAFE_F00D);
        chk("sw_write_cycles", wr_cnt, 2);
        chk("sw_done", 32'(store_done), 1);
        tick();

        // Refused requests
        fault_op("sw_misaligned", OP_STORE, 3'b010, 32'h0000_4002);
        fault_op("lh_misaligned", OP_LOAD, 3'b001, 32'h0000_4001);
        fault_op("store_f3_100", OP_STORE, 3'b100, 32'h0000_4000);
        fault_op("load_f3_011", OP_LOAD, 3'b011, 32'h0000_4000);
        fault_op("lw_misaligned", OP_LOAD, 3'b010, 32'h0000_4001);

        // Non-memory opcode is ignored
        req_valid    = 1'b1;
        opcode       = OP_ALU;
        funct3       = 3'b010;
        read_address = 32'h0000_4002;
        #1;
        chk("alu_stall", 32'(stall), 0);
        tick();
        req_valid = 1'b0;
        chk("alu_fault", 32'(fault), 0);
        chk("alu_strobes", 32'({bif.bus_read, bif.bus_write}), 0);

        // Timeout with no ack
        run_op(OP_LOAD, 3'b010, 32'h0000_5000, 32'd0, 0, 32'd0);
        chk("to_read_cycles", rd_cnt, 4);
        chk("to_error", 32'(bus_error), 1);
        chk("to_no_lvalid", 32'(load_valid), 0);
        chk("to_load_data", load_data, 0);
        chk("to_stall_done", 32'(stall), 0);
        tick();
        chk("to_error_pulse", 32'(bus_error), 0);

        // Ack in the expiring cycle wins
        run_op(OP_LOAD, 3'b010, 32'h0000_5004, 32'd0, 4, 32'h1357_9BDF);
        chk("to_ack_read_cycles", rd_cnt, 4);
        chk("to_ack_valid", 32'(load_valid), 1);
        chk("to_ack_error", 32'(bus_error), 0);
        chk("to_ack_data", load_data, 32'h1357_9BDF);
        tick();

        // Reset in the second BUS cycle of an LW
        req_valid     = 1'b1;
        opcode        = OP_LOAD;
        funct3        = 3'b010;
        read_address  = 32'h0000_6008;
        write_address = OTHER_ADDR;
        tick();
        req_valid = 1'b0;
        chk("rm_read_cycle1", 32'(bif.bus_read), 1);
        tick();
        rst = 1'b0;
        #1;
        chk("rm_strobes", 32'({bif.bus_read, bif.bus_write}), 0);
        chk("rm_addr", bif.bus_addr, 0);
        chk("rm_stall", 32'(stall), 0);
        chk("rm_load_data", load_data, 0);
        tick();
        rst           = 1'b1;
        bif.bus_ack   = 1'b1;
        bif.bus_rdata = 32'hFFFF_FFFF;
        tick();
        bif.bus_ack = 1'b0;
        chk("rm_no_lvalid", 32'(load_valid), 0);
        chk("rm_idle_ack_strobes", 32'({bif.bus_read, bif.bus_write}), 0);
        tick();
        chk("rm_no_lvalid2", 32'(load_valid), 0);
        chk("rm_load_data_kept", load_data, 0);
        run_op(OP_LOAD, 3'b010, 32'h0000_6008, 32'd0, 2, 32'h0BAD_F00D);
        chk("rm_new_read_cycles", rd_cnt, 2);
        chk("rm_new_valid", 32'(load_valid), 1);
        chk("rm_new_data", load_data, 32'h0BAD_F00D);
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
